// File: rtl/mac_accumulate_stream.sv
// Streaming signed multiply-accumulate: one dot product per last-delimited
// vector, saturating accumulator, result held on a valid/ready output.
module mac_accumulate_stream #(
  parameter int unsigned InWidth  = 8,
  parameter int unsigned AccWidth = 32
) (
  input  logic                clock,
  input  logic                reset_ni,
  input  logic [InWidth-1:0]  a_i,
  input  logic [InWidth-1:0]  b_i,
  input  logic                last_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [AccWidth-1:0] acc_o,
  output logic                sat_o,
  output logic                valid_o,
  input  logic                ready_i
);

  localparam int unsigned ProdWidth = 2 * InWidth;
  localparam int unsigned SumWidth  = AccWidth + 1;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic                         ready_q, ready_d;
  logic                         valid_q, valid_d;
  logic signed [ProdWidth-1:0]  prod_q, prod_d;
  logic                         plast_q, plast_d;
  logic                         pvalid_q, pvalid_d;
  logic        [AccWidth-1:0]   acc_q, acc_d;
  logic                         sat_q, sat_d;

  logic                         accept;
  logic signed [ProdWidth-1:0]  a_ext, b_ext;
  logic        [SumWidth-1:0]   sum;
  logic                         ovf;

  // Ready is held low while reset is asserted, independent of the flop.
  assign ready_o = ready_q & reset_ni;
  assign valid_o = valid_q;
  assign acc_o   = acc_q;
  assign sat_o   = sat_q;

  assign accept = valid_i & ready_o;

  // Sign-extend operands so the product is exact at full precision.
  assign a_ext = {{InWidth{a_i[InWidth-1]}}, a_i};
  assign b_ext = {{InWidth{b_i[InWidth-1]}}, b_i};

  // One-bit-wider sum; overflow when the two top bits disagree.
  assign sum = {acc_q[AccWidth-1], acc_q}
             + {{(SumWidth-ProdWidth){prod_q[ProdWidth-1]}}, prod_q};
  assign ovf = sum[AccWidth] ^ sum[AccWidth-1];

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= ACCUM;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      prod_q   <= '0;
      plast_q  <= 1'b0;
      pvalid_q <= 1'b0;
      acc_q    <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      prod_q   <= prod_d;
      plast_q  <= plast_d;
      pvalid_q <= pvalid_d;
      acc_q    <= acc_d;
      sat_q    <= sat_d;
    end
  end

  // Next-state: multiply stage, saturating accumulate, vector FSM.
  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    prod_d   = prod_q;
    plast_d  = plast_q;
    pvalid_d = 1'b0;
    acc_d    = acc_q;
    sat_d    = sat_q;

    if (accept) begin
      prod_d   = a_ext * b_ext;
      plast_d  = last_i;
      pvalid_d = 1'b1;
    end

    if (pvalid_q) begin
      if (ovf) begin
        // Clamp toward the sign of the true sum; later adds continue from here.
        acc_d = sum[AccWidth] ? {1'b1, {(AccWidth-1){1'b0}}}
                              : {1'b0, {(AccWidth-1){1'b1}}};
        sat_d = 1'b1;
      end else begin
        acc_d = sum[AccWidth-1:0];
      end
    end

    case (state_q)
      ACCUM: begin
        if (accept && last_i) begin
          state_d = FLUSH;
          ready_d = 1'b0;
        end
      end
      FLUSH: begin
        if (pvalid_q && plast_q) begin
          state_d = HOLD;
          valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (ready_i) begin
          state_d = ACCUM;
          valid_d = 1'b0;
          ready_d = 1'b1;
          acc_d   = '0;
          sat_d   = 1'b0;
        end
      end
      default: begin
        state_d = ACCUM;
        ready_d = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_accumulate_stream.sv
// Directed bench for mac_accumulate_stream: a 32-bit and a 16-bit accumulator
// see the same stream and are checked against a saturating reference model.
module tb_mac_accumulate_stream;

  typedef struct {
    longint acc32;
    bit     sat32;
    longint acc16;
    bit     sat16;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_ni = 1'b0;
  logic [7:0]  a_i = '0;
  logic [7:0]  b_i = '0;
  logic        last_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b1;

  logic [31:0] acc32;
  logic        sat32, valid32, ready32;
  logic [15:0] acc16;
  logic        sat16, valid16, ready16;

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc = 0;

  exp_t        sb[$];
  longint      m_acc[2];
  bit          m_sat[2];
  int          m_w[2] = '{32, 16};

  mac_accumulate_stream #(.InWidth(8), .AccWidth(32)) dut32 (
    .clock(clock), .reset_ni(reset_ni), .a_i(a_i), .b_i(b_i),
    .last_i(last_i), .valid_i(valid_i), .ready_o(ready32),
    .acc_o(acc32), .sat_o(sat32), .valid_o(valid32), .ready_i(ready_i)
  );

  mac_accumulate_stream #(.InWidth(8), .AccWidth(16)) dut16 (
    .clock(clock), .reset_ni(reset_ni), .a_i(a_i), .b_i(b_i),
    .last_i(last_i), .valid_i(valid_i), .ready_o(ready16),
    .acc_o(acc16), .sat_o(sat16), .valid_o(valid16), .ready_i(ready_i)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0;
      m_sat[i] = 1'b0;
    end
  endtask

  task automatic model_add(input longint p);
    longint mx, mn, t;
    for (int i = 0; i < 2; i++) begin
      mx = (longint'(1) <<< (m_w[i] - 1)) - 1;
      mn = -mx - 1;
      t  = m_acc[i] + p;
      if (t > mx) begin
        m_acc[i] = mx;
        m_sat[i] = 1'b1;
      end else if (t < mn) begin
        m_acc[i] = mn;
        m_sat[i] = 1'b1;
      end else begin
        m_acc[i] = t;
      end
    end
  endtask

  // Present one beat; returns just after the negedge following acceptance.
  task automatic send_beat(input int a, input int b, input bit last);
    int   n;
    exp_t e;
    n = 0;
    a_i = 8'(a);
    b_i = 8'(b);
    last_i = last;
    valid_i = 1'b1;
    while (!ready32 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("accept_wait_ok", longint'(n < 40), 1);
    @(negedge clock);
    valid_i = 1'b0;
    last_i = 1'b0;
    model_add(longint'(a) * longint'(b));
    if (last) begin
      e.acc32 = m_acc[0];
      e.sat32 = m_sat[0];
      e.acc16 = m_acc[1];
      e.sat16 = m_sat[1];
      sb.push_back(e);
      model_clear();
    end
  endtask

  // Wait for a result, compare against the scoreboard, and complete the
  // handshake if ready_i is high. exp_wait < 0 skips the latency check.
  task automatic expect_result(input string tag, input int exp_wait,
                               output int unsigned seen_cyc);
    int   n;
    exp_t e;
    n = 0;
    while (!valid32 && n < 40) begin
      @(negedge clock);
      n++;
    end
    seen_cyc = cyc;
    check({tag, "_valid_wait_ok"}, longint'(n < 40), 1);
    if (exp_wait >= 0) check({tag, "_edges_to_valid"}, longint'(n), longint'(exp_wait));
    check({tag, "_valid16"}, longint'(valid16), 1);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s_scoreboard: observed result with no expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_acc32"}, longint'($signed(acc32)), e.acc32);
      check({tag, "_sat32"}, longint'(sat32), longint'(e.sat32));
      check({tag, "_acc16"}, longint'($signed(acc16)), e.acc16);
      check({tag, "_sat16"}, longint'(sat16), longint'(e.sat16));
    end
    if (ready_i) begin
      @(negedge clock);
      check({tag, "_valid_after_hs"}, longint'(valid32), 0);
      check({tag, "_ready_after_hs"}, longint'(ready32), 1);
    end
  endtask

  initial begin
    int unsigned t1, t2;
    model_clear();

    // Reset state.
    repeat (2) @(negedge clock);
    check("rst_ready", longint'(ready32), 0);
    check("rst_valid", longint'(valid32), 0);
    check("rst_acc", longint'(acc32), 0);
    check("rst_sat", longint'(sat32), 0);
    reset_ni = 1'b1;
    #1;
    check("rst_release_ready", longint'(ready32), 1);
    @(negedge clock);

    // Basic dot product, exact latency.
    send_beat(3, 4, 1'b0);
    send_beat(-2, 5, 1'b0);
    send_beat(7, -1, 1'b1);
    check("basic_no_early_valid", longint'(valid32), 0);
    expect_result("basic", 1, t1);

    // Single-beat vector at the operand extreme.
    send_beat(-128, -128, 1'b1);
    expect_result("single", 1, t1);

    // Saturation in the 16-bit instance, then a clean vector.
    send_beat(-128, -128, 1'b0);
    send_beat(-128, -128, 1'b0);
    send_beat(-1, 1, 1'b1);
    expect_result("sat", 1, t1);
    send_beat(1, 1, 1'b1);
    expect_result("after_sat", 1, t1);

    // Gapped valid_i, then output backpressure with a stray beat offered.
    for (int i = 0; i < 4; i++) begin
      send_beat(1, 2, i == 3);
      if (i != 3) @(negedge clock);
    end
    ready_i = 1'b0;
    expect_result("gaps", 1, t1);
    a_i = 8'd100;
    b_i = 8'd100;
    last_i = 1'b1;
    valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_valid", longint'(valid32), 1);
      check("stall_ready", longint'(ready32), 0);
      check("stall_acc", longint'($signed(acc32)), 8);
    end
    valid_i = 1'b0;
    last_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clock);
    check("stall_release_valid", longint'(valid32), 0);
    check("stall_release_ready", longint'(ready32), 1);

    // Reset mid-vector discards the partial sum.
    send_beat(10, 10, 1'b0);
    send_beat(10, 10, 1'b0);
    reset_ni = 1'b0;
    #1;
    check("midrst_ready", longint'(ready32), 0);
    check("midrst_valid", longint'(valid32), 0);
    check("midrst_acc", longint'(acc32), 0);
    @(negedge clock);
    reset_ni = 1'b1;
    model_clear();
    #1;
    check("midrst_release_ready", longint'(ready32), 1);
    send_beat(1, 1, 1'b1);
    expect_result("post_rst", 1, t1);

    // Back-to-back single-beat vectors.
    send_beat(2, 3, 1'b1);
    expect_result("b2b_first", 1, t1);
    send_beat(4, 5, 1'b1);
    expect_result("b2b_second", 1, t2);
    check("b2b_spacing", longint'(t2) - longint'(t1), 3);

    check("scoreboard_empty", longint'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
